// File: rtl/wave_pwm_dac.sv
// -----------------------------------------------------------------------------
// wave_pwm_dac
//
// PWM output stage for the function generator. Each incoming 8-bit waveform
// sample is scaled (gain in Q1.7, signed offset) and clamped to 0..255. At
// every PWM period boundary the latest scaled value becomes the duty for the
// next 256-tick period. Because the duty only changes at a boundary, the
// output never glitches mid-period. pwm_out drives an external RC low-pass
// filter that turns the duty into an analog level.
//
// Ports
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   enable        level, run the PWM output (drains to a period end on drop)
//   sample_in     unsigned 8-bit waveform sample
//   gain          unsigned gain, 0x80 = 1.0
//   offset        9-bit two's-complement offset added after the gain
//   prescale      PWM tick divider, one tick every prescale+1 clocks
//   pwm_out       registered PWM pin
//   held_duty     duty value currently being played
//   sample_strobe one-cycle pulse in the cycle held_duty shows a new sample
//   clip          sticky saturation flag
//   clip_clr      synchronous clear of clip (a new saturation wins)
//   busy          high while the PWM is running or draining
// -----------------------------------------------------------------------------
module wave_pwm_dac #(
    parameter int         PRESCALE_W = 8,
    parameter logic [7:0] RESET_DUTY = 8'd0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [7:0]            sample_in,
    input  logic [7:0]            gain,
    input  logic [8:0]            offset,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  pwm_out,
    output logic [7:0]            held_duty,
    output logic                  sample_strobe,
    output logic                  clip,
    input  logic                  clip_clr,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state_reg;
    state_t state_next;

    // -------------------------------------------------------------------------
    // Scaling pipeline (runs every cycle regardless of state)
    // -------------------------------------------------------------------------
    logic [15:0]        prod_reg;
    logic [7:0]         scaled_reg;
    logic               sat_reg;
    logic signed [10:0] sum;
    logic               sat_lo;
    logic               sat_hi;
    logic [7:0]         scaled_next;

    // prod>>7 is at most 510 and the offset spans -256..255, so an 11-bit
    // signed sum holds every result without overflow.
    assign sum    = $signed({2'b00, prod_reg[15:7]}) + $signed({{2{offset[8]}}, offset});
    assign sat_lo = sum[10];
    assign sat_hi = !sum[10] && (sum[9:8] != 2'b00);

    always_comb begin
        scaled_next = sum[7:0];
        if (sat_lo) begin
            scaled_next = 8'd0;
        end else if (sat_hi) begin
            scaled_next = 8'hFF;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_reg   <= 16'd0;
            scaled_reg <= 8'd0;
            sat_reg    <= 1'b0;
        end else begin
            prod_reg   <= sample_in * gain;
            scaled_reg <= scaled_next;
            sat_reg    <= sat_lo || sat_hi;
        end
    end

    // After reset the pipeline holds zeros, not real samples. Counting two
    // clocks of refill keeps the first played duty from being that garbage.
    logic [1:0] fill_cnt_reg;
    logic       pipe_ready;

    assign pipe_ready = (fill_cnt_reg == 2'd2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_cnt_reg <= 2'd0;
        end else if (!pipe_ready) begin
            fill_cnt_reg <= fill_cnt_reg + 2'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Sticky clip flag; a saturation in the same cycle beats the clear.
    // -------------------------------------------------------------------------
    logic clip_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clip_reg <= 1'b0;
        end else if (sat_reg) begin
            clip_reg <= 1'b1;
        end else if (clip_clr) begin
            clip_reg <= 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Prescaler and PWM counter
    // -------------------------------------------------------------------------
    logic [PRESCALE_W-1:0] pre_cnt_reg;
    logic [7:0]            pwm_cnt_reg;
    logic                  running;
    logic                  tick;
    logic                  boundary;

    assign running  = (state_reg != IDLE);
    // ">=" rather than "==" so that shrinking prescale below the current
    // count still produces a tick and a wrap instead of a long run-out.
    assign tick     = running && (pre_cnt_reg >= prescale);
    assign boundary = tick && (pwm_cnt_reg == 8'hFF);

    // -------------------------------------------------------------------------
    // State machine: next state and control strobes
    // -------------------------------------------------------------------------
    logic start;        // IDLE -> RUN: load first sample, clear counters
    logic load_sample;  // period boundary while continuing to run
    logic go_idle;      // drain finished at a boundary

    always_comb begin
        state_next  = state_reg;
        start       = 1'b0;
        load_sample = 1'b0;
        go_idle     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (enable && pipe_ready) begin
                    state_next = RUN;
                    start      = 1'b1;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_next = DRAIN;
                end
                load_sample = boundary;
            end
            DRAIN: begin
                if (enable) begin
                    // Re-enabled before the period ended: resume without
                    // touching the counters.
                    state_next  = RUN;
                    load_sample = boundary;
                end else if (boundary) begin
                    state_next = IDLE;
                    go_idle    = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Counters
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt_reg <= '0;
        end else if (!running || start || go_idle || tick) begin
            pre_cnt_reg <= '0;
        end else begin
            pre_cnt_reg <= pre_cnt_reg + PRESCALE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt_reg <= 8'd0;
        end else if (start || go_idle) begin
            pwm_cnt_reg <= 8'd0;
        end else if (tick) begin
            pwm_cnt_reg <= pwm_cnt_reg + 8'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Held duty, strobe and PWM pin
    // -------------------------------------------------------------------------
    logic [7:0] held_duty_reg;
    logic       strobe_reg;
    logic       pwm_out_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_duty_reg <= RESET_DUTY;
        end else if (start || load_sample) begin
            held_duty_reg <= scaled_reg;
        end else if (go_idle) begin
            held_duty_reg <= RESET_DUTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strobe_reg  <= 1'b0;
            pwm_out_reg <= 1'b0;
        end else begin
            strobe_reg  <= start || load_sample;
            pwm_out_reg <= running && (pwm_cnt_reg < held_duty_reg);
        end
    end

    assign pwm_out       = pwm_out_reg;
    assign held_duty     = held_duty_reg;
    assign sample_strobe = strobe_reg;
    assign clip          = clip_reg;
    assign busy          = running;

endmodule

// File: tb/tb_wave_pwm_dac.sv
// -----------------------------------------------------------------------------
// tb_wave_pwm_dac
//
// Directed bench for wave_pwm_dac. Each scenario task drives its own stimulus
// and compares outputs against hand-computed values, sampling on the falling
// clock edge. One line is printed per scenario, plus one line per mismatch.
// -----------------------------------------------------------------------------
module tb_wave_pwm_dac;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic [7:0] sample_in;
    logic [7:0] gain;
    logic [8:0] offset;
    logic [7:0] prescale;
    logic       pwm_out;
    logic [7:0] held_duty;
    logic       sample_strobe;
    logic       clip;
    logic       clip_clr;
    logic       busy;

    int checks;
    int passed;

    wave_pwm_dac #(
        .PRESCALE_W(8),
        .RESET_DUTY(8'd0)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .sample_in    (sample_in),
        .gain         (gain),
        .offset       (offset),
        .prescale     (prescale),
        .pwm_out      (pwm_out),
        .held_duty    (held_duty),
        .sample_strobe(sample_strobe),
        .clip         (clip),
        .clip_clr     (clip_clr),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reset, load inputs, let the pipeline fill, then raise enable. Returns at
    // the falling edge right after the IDLE->RUN clock.
    task automatic start_run(input logic [7:0] s, input logic [7:0] g,
                             input logic [8:0] o, input logic [7:0] p);
        @(negedge clk);
        enable    = 1'b0;
        clip_clr  = 1'b0;
        sample_in = s;
        gain      = g;
        offset    = o;
        prescale  = p;
        rst_n     = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
    endtask

    // From a strobe, count clocks to the next strobe and pwm_out highs.
    task automatic measure(input int max_clk, output int len, output int highs);
        len   = -1;
        highs = 0;
        for (int i = 1; i <= max_clk; i++) begin
            @(negedge clk);
            highs += int'(pwm_out);
            if (sample_strobe) begin
                len = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; clip_clr = 1'b0;
        sample_in = 8'd0; gain = 8'd0; offset = 9'd0; prescale = 8'd0;
        repeat (3) @(negedge clk);
        checks++; if (pwm_out !== 1'b0) $display("FAIL reset_pwm_out got %b want 0", pwm_out); else passed++;
        checks++; if (held_duty !== 8'd0) $display("FAIL reset_held_duty got %0d want 0", held_duty); else passed++;
        checks++; if (sample_strobe !== 1'b0) $display("FAIL reset_strobe got %b want 0", sample_strobe); else passed++;
        checks++; if (clip !== 1'b0) $display("FAIL reset_clip got %b want 0", clip); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checks++; if (busy !== 1'b0) $display("FAIL idle_busy got %b want 0", busy); else passed++;
        $display("test_reset done");
    endtask

    task automatic test_unity();
        int len, highs;
        start_run(8'd200, 8'h80, 9'd0, 8'd0);
        checks++; if (sample_strobe !== 1'b1) $display("FAIL unity_entry_strobe got %b want 1", sample_strobe); else passed++;
        checks++; if (held_duty !== 8'd200) $display("FAIL unity_held got %0d want 200", held_duty); else passed++;
        measure(400, len, highs);
        checks++; if (len !== 256) $display("FAIL unity_period got %0d want 256", len); else passed++;
        checks++; if (highs !== 200) $display("FAIL unity_highs got %0d want 200", highs); else passed++;
        checks++; if (clip !== 1'b0) $display("FAIL unity_clip got %b want 0", clip); else passed++;
        $display("test_unity done: period=%0d highs=%0d", len, highs);
    endtask

    task automatic test_clip();
        int len, highs;
        start_run(8'd200, 8'hFF, 9'd0, 8'd0);
        checks++; if (sample_strobe !== 1'b1) $display("FAIL clip_entry_strobe got %b want 1", sample_strobe); else passed++;
        checks++; if (held_duty !== 8'd255) $display("FAIL clip_held got %0d want 255", held_duty); else passed++;
        checks++; if (clip !== 1'b1) $display("FAIL clip_set got %b want 1", clip); else passed++;
        measure(400, len, highs);
        checks++; if (len !== 256) $display("FAIL clip_period got %0d want 256", len); else passed++;
        checks++; if (highs !== 255) $display("FAIL clip_highs got %0d want 255", highs); else passed++;
        // Move to a non-saturating sample mid-period: flag must stay, duty must hold.
        sample_in = 8'd10;
        gain      = 8'h80;
        repeat (5) @(negedge clk);
        checks++; if (clip !== 1'b1) $display("FAIL clip_sticky got %b want 1", clip); else passed++;
        checks++; if (held_duty !== 8'd255) $display("FAIL clip_held_midperiod got %0d want 255", held_duty); else passed++;
        clip_clr = 1'b1;
        @(negedge clk);
        clip_clr = 1'b0;
        checks++; if (clip !== 1'b0) $display("FAIL clip_cleared got %b want 0", clip); else passed++;
        measure(400, len, highs);
        checks++; if (held_duty !== 8'd10) $display("FAIL clip_next_held got %0d want 10", held_duty); else passed++;
        checks++; if (clip !== 1'b0) $display("FAIL clip_stays_clear got %b want 0", clip); else passed++;
        $display("test_clip done: held=%0d clip=%b", held_duty, clip);
    endtask

    task automatic test_negative();
        int len, highs;
        start_run(8'd10, 8'h80, 9'h1EC, 8'd0);
        checks++; if (sample_strobe !== 1'b1) $display("FAIL neg_entry_strobe got %b want 1", sample_strobe); else passed++;
        checks++; if (held_duty !== 8'd0) $display("FAIL neg_held got %0d want 0", held_duty); else passed++;
        checks++; if (clip !== 1'b1) $display("FAIL neg_clip got %b want 1", clip); else passed++;
        measure(400, len, highs);
        checks++; if (len !== 256) $display("FAIL neg_period got %0d want 256", len); else passed++;
        checks++; if (highs !== 0) $display("FAIL neg_highs got %0d want 0", highs); else passed++;
        $display("test_negative done: held=%0d highs=%0d", held_duty, highs);
    endtask

    task automatic test_prescale();
        int len, highs, moved;
        // 34*0x80>>7 = 34, +30 offset = 64
        start_run(8'd34, 8'h80, 9'd30, 8'd3);
        checks++; if (sample_strobe !== 1'b1) $display("FAIL ps_entry_strobe got %b want 1", sample_strobe); else passed++;
        checks++; if (held_duty !== 8'd64) $display("FAIL ps_held got %0d want 64", held_duty); else passed++;
        measure(2000, len, highs);
        checks++; if (len !== 1024) $display("FAIL ps_period got %0d want 1024", len); else passed++;
        checks++; if (highs !== 256) $display("FAIL ps_highs got %0d want 256", highs); else passed++;
        repeat (300) @(negedge clk);
        sample_in = 8'd100;                        // 100 + 30 = 130
        moved = 0;
        len   = -1;
        for (int i = 301; i <= 2000; i++) begin
            @(negedge clk);
            if (sample_strobe) begin
                len = i;
                break;
            end
            if (held_duty !== 8'd64) moved++;
        end
        checks++; if (moved !== 0) $display("FAIL ps_held_midperiod got %0d changed cycles want 0", moved); else passed++;
        checks++; if (len !== 1024) $display("FAIL ps_second_period got %0d want 1024", len); else passed++;
        checks++; if (held_duty !== 8'd130) $display("FAIL ps_new_held got %0d want 130", held_duty); else passed++;
        $display("test_prescale done: held=%0d", held_duty);
    endtask

    task automatic test_drain();
        int highs, drops;
        start_run(8'd200, 8'h80, 9'd0, 8'd0);
        checks++; if (sample_strobe !== 1'b1) $display("FAIL drain_entry_strobe got %b want 1", sample_strobe); else passed++;
        repeat (100) @(negedge clk);               // pwm_cnt = 100
        enable = 1'b0;
        highs = 0;
        drops = 0;
        for (int k = 1; k <= 156; k++) begin
            @(negedge clk);
            highs += int'(pwm_out);
            if (k < 156 && busy !== 1'b1) drops++;
        end
        checks++; if (drops !== 0) $display("FAIL drain_busy_held got %0d idle cycles want 0", drops); else passed++;
        checks++; if (highs !== 100) $display("FAIL drain_highs got %0d want 100", highs); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL drain_idle_busy got %b want 0", busy); else passed++;
        checks++; if (held_duty !== 8'd0) $display("FAIL drain_idle_held got %0d want 0", held_duty); else passed++;
        checks++; if (sample_strobe !== 1'b0) $display("FAIL drain_no_strobe got %b want 0", sample_strobe); else passed++;
        repeat (3) @(negedge clk);
        checks++; if (pwm_out !== 1'b0) $display("FAIL drain_idle_pwm got %b want 0", pwm_out); else passed++;
        $display("test_drain done: highs=%0d", highs);
    endtask

    task automatic test_drain_reenable();
        int drops, first;
        start_run(8'd200, 8'h80, 9'd0, 8'd0);
        checks++; if (sample_strobe !== 1'b1) $display("FAIL reen_entry_strobe got %b want 1", sample_strobe); else passed++;
        repeat (100) @(negedge clk);               // pwm_cnt = 100
        enable = 1'b0;
        repeat (100) @(negedge clk);               // pwm_cnt = 200
        enable = 1'b1;
        drops = 0;
        first = -1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (busy !== 1'b1) drops++;
            if (sample_strobe && first < 0) first = k;
        end
        checks++; if (drops !== 0) $display("FAIL reen_busy got %0d idle cycles want 0", drops); else passed++;
        checks++; if (first !== 56) $display("FAIL reen_boundary got %0d want 56", first); else passed++;
        checks++; if (held_duty !== 8'd200) $display("FAIL reen_held got %0d want 200", held_duty); else passed++;
        $display("test_drain_reenable done: boundary after %0d clocks", first);
    endtask

    task automatic test_async_reset();
        int first;
        start_run(8'd200, 8'h80, 9'd0, 8'd0);
        repeat (10) @(negedge clk);
        checks++; if (pwm_out !== 1'b1) $display("FAIL arst_pre_pwm got %b want 1", pwm_out); else passed++;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (pwm_out !== 1'b0) $display("FAIL arst_pwm got %b want 0", pwm_out); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL arst_busy got %b want 0", busy); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        first = -1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (sample_strobe && first < 0) first = k;
        end
        checks++; if (first !== 3) $display("FAIL arst_restart_strobe got %0d want 3", first); else passed++;
        checks++; if (held_duty !== 8'd200) $display("FAIL arst_restart_held got %0d want 200", held_duty); else passed++;
        $display("test_async_reset done: strobe on clock %0d", first);
    endtask

    initial begin
        checks = 0;
        passed = 0;
        test_reset();
        test_unity();
        test_clip();
        test_negative();
        test_prescale();
        test_drain();
        test_drain_reenable();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
